// File: rtl/mmio_io_hub.sv
// mmio_io_hub: memory-mapped I/O hub between the processor data port, data RAM,
// the PS2 key FIFO and the VGA output registers.
// Build option: define MMIO_SHADOW_EN to drive regs_out from frame-synchronous
// shadow registers; undefined drives regs_out straight from the working registers.
module mmio_io_hub #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned RAM_LIMIT  = 2000,
  parameter int unsigned MMIO_BASE  = 3000,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned REG_W      = 10,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [ADDR_W-1:0]         address,
  input  logic [31:0]               wdata,
  input  logic                      wren,
  input  logic [31:0]               ram_q,
  output logic                      ram_wren,
  output logic [31:0]               rdata,
  input  logic                      key_valid,
  input  logic [7:0]                key_data,
  input  logic                      frame_sync,
  output logic [NUM_REGS*REG_W-1:0] regs_out
);

  localparam int unsigned PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W        = PTR_W + 1;
  localparam int unsigned OFF_KEY_DATA = NUM_REGS;
  localparam int unsigned OFF_KEY_POP  = NUM_REGS + 1;
  localparam int unsigned OFF_STATUS   = NUM_REGS + 2;

  typedef enum logic [1:0] {
    RD_RAM  = 2'd0,
    RD_MMIO = 2'd1,
    RD_ZERO = 2'd2
  } rd_cls_e;

  // Address decode
  logic [31:0]         addr_ext_c;
  logic [31:0]         mmio_off_c;
  logic                is_ram_c;
  logic                in_mmio_c;
  logic [NUM_REGS-1:0] reg_we_c;
  logic                pop_req_c;
  logic                ovf_clr_c;

  // Working / output registers
  logic [REG_W-1:0] work [NUM_REGS];

  // Key FIFO state
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             key_prev;
  logic             push_q;
  logic [7:0]       push_data_q;
  logic             fifo_empty_c;
  logic             fifo_full_c;
  logic             pop_do_c;
  logic             push_do_c;

  // Read path
  rd_cls_e     rd_cls_c;
  rd_cls_e     rd_cls_q;
  logic [31:0] mmio_rd_c;
  logic [31:0] mmio_rd_q;

  // Upper write-data bits beyond REG_W are intentionally discarded
  logic unused_bits;

  // Classify the address and derive write strobes
  always_comb begin
    addr_ext_c = 32'(address);
    is_ram_c   = (addr_ext_c < RAM_LIMIT);
    in_mmio_c  = !is_ram_c && (addr_ext_c >= MMIO_BASE);
    mmio_off_c = addr_ext_c - MMIO_BASE;
    reg_we_c   = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_we_c[i] = wren && in_mmio_c && (mmio_off_c == i);
    end
    pop_req_c = wren && in_mmio_c && (mmio_off_c == OFF_KEY_POP);
    ovf_clr_c = wren && in_mmio_c && (mmio_off_c == OFF_STATUS);
  end

  assign ram_wren = wren && is_ram_c;

  // Working registers, written by the processor
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) work[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (reg_we_c[i]) work[i] <= wdata[REG_W-1:0];
      end
    end
  end

`ifdef MMIO_SHADOW_EN
  logic             fs_meta;
  logic             fs_sync;
  logic             fs_prev;
  logic             frame_rise_c;
  logic [REG_W-1:0] shadow [NUM_REGS];

  // Two-flop synchronizer plus rising-edge detect on frame_sync
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fs_meta <= 1'b0;
      fs_sync <= 1'b0;
      fs_prev <= 1'b0;
    end else begin
      fs_meta <= frame_sync;
      fs_sync <= fs_meta;
      fs_prev <= fs_sync;
    end
  end

  assign frame_rise_c = fs_sync && !fs_prev;

  // Shadow copies snapshot the working registers once per frame
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (frame_rise_c) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= work[i];
    end
  end

  // Pack the shadow registers onto regs_out
  always_comb begin
    regs_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_out[i*REG_W +: REG_W] = shadow[i];
    end
  end

  assign unused_bits = ^wdata;
`else
  // Pack the working registers onto regs_out
  always_comb begin
    regs_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_out[i*REG_W +: REG_W] = work[i];
    end
  end

  assign unused_bits = ^{wdata, frame_sync};
`endif

  // Key edge detect; the byte is captured in the cycle the rise is seen
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_prev    <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      key_prev    <= key_valid;
      push_q      <= key_valid && !key_prev;
      push_data_q <= key_data;
    end
  end

  // FIFO push/pop qualification; a full FIFO still accepts a push when popped
  always_comb begin
    fifo_empty_c = (count == '0);
    fifo_full_c  = (count == CNT_W'(FIFO_DEPTH));
    pop_do_c     = pop_req_c && !fifo_empty_c;
    push_do_c    = push_q && (!fifo_full_c || pop_do_c);
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_do_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_do_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_do_c && !pop_do_c)      count <= count + CNT_W'(1);
      else if (pop_do_c && !push_do_c) count <= count - CNT_W'(1);
      if (push_q && !push_do_c)        overflow <= 1'b1;
      else if (ovf_clr_c)              overflow <= 1'b0;
    end
  end

  // FIFO storage; contents are meaningless outside the valid window
  always_ff @(posedge clock) begin
    if (push_do_c) fifo_mem[wr_ptr] <= push_data_q;
  end

  // MMIO read value for the presented address
  always_comb begin
    mmio_rd_c = '0;
    rd_cls_c  = RD_ZERO;
    if (is_ram_c) begin
      rd_cls_c = RD_RAM;
    end else if (in_mmio_c) begin
      rd_cls_c = RD_MMIO;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (mmio_off_c == i) mmio_rd_c = 32'(work[i]);
      end
      if (mmio_off_c == OFF_KEY_DATA && !fifo_empty_c) begin
        mmio_rd_c = 32'(fifo_mem[rd_ptr]);
      end
      if (mmio_off_c == OFF_STATUS) begin
        mmio_rd_c = {16'd0, 1'b0, 7'(count), 5'd0, overflow, fifo_full_c, fifo_empty_c};
      end
    end
  end

  // Register the read class and value to line up with the RAM latency
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_cls_q  <= RD_RAM;
      mmio_rd_q <= '0;
    end else begin
      rd_cls_q  <= rd_cls_c;
      mmio_rd_q <= mmio_rd_c;
    end
  end

  // Return RAM data or the registered MMIO value
  always_comb begin
    rdata = '0;
    case (rd_cls_q)
      RD_RAM:  rdata = ram_q;
      RD_MMIO: rdata = mmio_rd_q;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_io_hub.sv
// tb_mmio_io_hub: scoreboard bench for mmio_io_hub (RAM gating, output registers,
// key FIFO, read mux). Exercises shadowing when MMIO_SHADOW_EN is defined.
module tb_mmio_io_hub;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned REG_W    = 10;
  localparam int unsigned A        = 3000;
  localparam int unsigned KD       = A + NUM_REGS;
  localparam int unsigned KP       = A + NUM_REGS + 1;
  localparam int unsigned ST       = A + NUM_REGS + 2;

  logic                      clock = 1'b0;
  logic                      resetn;
  logic [ADDR_W-1:0]         address;
  logic [31:0]               wdata;
  logic                      wren;
  logic [31:0]               ram_q;
  logic                      ram_wren;
  logic [31:0]               rdata;
  logic                      key_valid;
  logic [7:0]                key_data;
  logic                      frame_sync;
  logic [NUM_REGS*REG_W-1:0] regs_out;

  mmio_io_hub #(
    .ADDR_W(ADDR_W), .RAM_LIMIT(2000), .MMIO_BASE(A),
    .NUM_REGS(NUM_REGS), .REG_W(REG_W), .FIFO_DEPTH(8)
  ) dut (
    .clock(clock), .resetn(resetn), .address(address), .wdata(wdata),
    .wren(wren), .ram_q(ram_q), .ram_wren(ram_wren), .rdata(rdata),
    .key_valid(key_valid), .key_data(key_data), .frame_sync(frame_sync),
    .regs_out(regs_out)
  );

  always #5 clock = ~clock;

  // Data RAM model: unwritten words read back as A500_0000 | address
  bit [31:0] tb_mem [4096];
  bit        tb_wr  [4096];
  always @(posedge clock) begin
    ram_q <= tb_wr[address] ? tb_mem[address] : (32'hA500_0000 | 32'(address));
    if (wren && (32'(address) < 2000)) begin
      tb_mem[address] <= wdata;
      tb_wr[address]  <= 1'b1;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Read scoreboard: expected data queued at issue, compared when rdata is due
  logic [31:0] exp_q [$];
  string       tag_q [$];
  bit          rd_pending = 1'b0;

  task automatic tick();
    @(posedge clock);
    #1;
    if (rd_pending) begin
      rd_pending = 1'b0;
      check(tag_q.pop_front(), 64'(rdata), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic rd(input int unsigned a, input logic [31:0] e, input string tag);
    address = ADDR_W'(a);
    wren    = 1'b0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    rd_pending = 1'b1;
    tick();
  endtask

  task automatic wr(input int unsigned a, input logic [31:0] d);
    address = ADDR_W'(a);
    wdata   = d;
    wren    = 1'b1;
    tick();
    wren    = 1'b0;
  endtask

  // Key FIFO reference model
  logic [7:0] mq [$];
  bit         movf = 1'b0;

  function automatic logic [31:0] st_exp();
    logic [31:0] s;
    s = (32'(mq.size()) << 8) | (32'(movf) << 2);
    if (mq.size() == 8) s = s | 32'd2;
    if (mq.size() == 0) s = s | 32'd1;
    return s;
  endfunction

  task automatic push_key(input logic [7:0] b);
    key_valid = 1'b1;
    key_data  = b;
    tick();
    key_valid = 1'b0;
    key_data  = 8'hEE;
    tick();
    if (mq.size() == 8) movf = 1'b1;
    else mq.push_back(b);
  endtask

  function automatic logic [39:0] pack(input logic [9:0] r0, input logic [9:0] r1,
                                        input logic [9:0] r2, input logic [9:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] keys [9];
    logic [9:0] r1;
    keys = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};

    resetn = 1'b0; address = '0; wdata = '0; wren = 1'b0;
    key_valid = 1'b0; key_data = '0; frame_sync = 1'b0;
    tick(); tick(); tick();
    check("rst_regs_out", 64'(regs_out), 64'd0);
    check("rst_rdata_ram", 64'(rdata), 64'h0000_0000_A500_0000);
    resetn = 1'b1;
    tick();
    rd(ST, 32'h1, "status_after_rst");
    rd(KD, 32'h0, "keydata_empty");

    // RAM write gating
    address = ADDR_W'(1999); wdata = 32'h55; wren = 1'b1; #1;
    check("ram_wren_1999", 64'(ram_wren), 64'd1);
    tick();
    address = ADDR_W'(2000); #1;
    check("ram_wren_2000", 64'(ram_wren), 64'd0);
    tick();
    address = ADDR_W'(A); wdata = 32'h3FF; #1;
    check("ram_wren_3000", 64'(ram_wren), 64'd0);
    tick();
    wren = 1'b0;
    wr(A + 3, 32'hFFFF_F123);
    rd(1999, 32'h55, "ram_read_1999");
    rd(2000, 32'h0, "read_gap_2000");
    rd(A, 32'h3FF, "reg0_read");
    rd(A + 3, 32'h123, "reg3_truncated");
    rd(KP, 32'h0, "keypop_read");

`ifdef MMIO_SHADOW_EN
    check("shadow_hold_init", 64'(regs_out), 64'd0);
    wr(A + 1, 32'h050);
    check("shadow_hold_write", 64'(regs_out), 64'd0);
    frame_sync = 1'b1;
    tick(); tick();
    check("shadow_before_edge3", 64'(regs_out), 64'd0);
    wr(A + 1, 32'h0AA);
    check("shadow_edge3", 64'(regs_out), 64'(pack(10'h3FF, 10'h050, 10'h0, 10'h123)));
    frame_sync = 1'b0;
    tick(); tick();
    check("shadow_deferred", 64'(regs_out), 64'(pack(10'h3FF, 10'h050, 10'h0, 10'h123)));
    frame_sync = 1'b1;
    tick(); tick(); tick();
    frame_sync = 1'b0;
    check("shadow_next_frame", 64'(regs_out), 64'(pack(10'h3FF, 10'h0AA, 10'h0, 10'h123)));
    r1 = 10'h0AA;
`else
    check("regs_out_direct", 64'(regs_out), 64'(pack(10'h3FF, 10'h0, 10'h0, 10'h123)));
    frame_sync = 1'b1;
    wr(A + 1, 32'h050);
    frame_sync = 1'b0;
    check("regs_out_reg1", 64'(regs_out), 64'(pack(10'h3FF, 10'h050, 10'h0, 10'h123)));
    r1 = 10'h050;
`endif
    rd(A + 1, 32'(r1), "reg1_read");

    // Fill past capacity
    for (int i = 0; i < 9; i++) push_key(keys[i]);
    rd(ST, st_exp(), "status_full_ovf");
    check("status_model_full", 64'(st_exp()), 64'h806);
    rd(KD, 32'(mq[0]), "keydata_head");
    wr(KD, 32'h77);
    rd(KD, 32'(mq[0]), "keydata_write_ignored");

    // Clear overflow, then simultaneous push and pop at full
    wr(ST, 32'h0);
    movf = 1'b0;
    rd(ST, st_exp(), "status_ovf_cleared");
    key_valid = 1'b1; key_data = 8'h4B;
    tick();
    key_valid = 1'b0; key_data = 8'hEE;
    wr(KP, 32'h0);
    void'(mq.pop_front());
    mq.push_back(8'h4B);
    rd(ST, st_exp(), "status_push_pop_full");
    rd(KD, 32'(mq[0]), "keydata_after_pushpop");

    // Drain in order
    for (int i = 0; i < 8; i++) begin
      rd(KD, 32'(mq[0]), "drain_keydata");
      wr(KP, 32'h0);
      void'(mq.pop_front());
    end
    rd(ST, st_exp(), "status_drained");
    rd(KD, 32'h0, "keydata_drained");
    wr(KP, 32'h0);
    rd(ST, 32'h1, "status_pop_empty");

    // Reset in the middle of filling
    wr(A + 2, 32'h1AB);
    push_key(8'h11);
    push_key(8'h22);
    rd(ST, st_exp(), "status_prefill");
    resetn = 1'b0;
    tick();
    check("midrst_regs_out", 64'(regs_out), 64'd0);
    resetn = 1'b1;
    mq.delete();
    movf = 1'b0;
    tick();
    rd(ST, st_exp(), "status_after_midrst");
    rd(A + 2, 32'h0, "reg2_after_midrst");
    rd(A, 32'h0, "reg0_after_midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
